// File: rtl/altmemddr_phy_pll_pkg.sv
// Shared types and constants for the PLL phase-step responder.
// State encoding, error flag positions and timeout counter width.
package altmemddr_phy_pll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    WAIT_LOW,
    WAIT_HIGH,
    COMPLETE
  } pll_state_e;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_BUSY    = 1;
  localparam int ERR_SELECT  = 2;

  localparam int TMO_W = 8;

endpackage

// File: rtl/altmemddr_phy_sync2.sv
// Two-flop synchroniser for asynchronous PLL status inputs.
// RST_VAL picks the idle level seen while in reset.
module altmemddr_phy_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic seq_clk,
  input  logic reset_seq_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge seq_clk or negedge reset_seq_n) begin
    if (!reset_seq_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/altmemddr_phy_pll_phase_step_ctrl.sv
// PLL dynamic phase-step responder: one step per sequencer request,
// phasedone handshake, per-clock phase tracking and sticky errors.
module altmemddr_phy_pll_phase_step_ctrl
  import altmemddr_phy_pll_pkg::*;
#(
  parameter int CLOCK_INDEX_WIDTH   = 3,
  parameter int NUM_CLOCKS          = 5,
  parameter int PLL_STEPS_PER_CYCLE = 72,
  parameter int PHASE_CNT_WIDTH     = 7,
  parameter int PHASESTEP_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES      = 255
) (
  input  logic                         seq_clk,
  input  logic                         reset_seq_n,
  input  logic                         pll_locked,
  input  logic                         seq_pll_start_reconfig,
  input  logic [CLOCK_INDEX_WIDTH-1:0] seq_pll_select,
  input  logic                         seq_pll_inc_dec_n,
  output logic                         phs_shft_busy,
  output logic [CLOCK_INDEX_WIDTH-1:0] pll_phasecounterselect,
  output logic                         pll_phaseupdown,
  output logic                         pll_phasestep,
  input  logic                         pll_phasedone,
  input  logic [CLOCK_INDEX_WIDTH-1:0] phase_query_index,
  output logic [PHASE_CNT_WIDTH-1:0]   phase_query_value,
  output logic [2:0]                   err_flags
);

  localparam int SCW =
    (PHASESTEP_CYCLES > 1) ? $clog2(PHASESTEP_CYCLES) : 1;
  localparam logic [SCW-1:0] STEP_LAST =
    SCW'(PHASESTEP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT =
    TMO_W'(TIMEOUT_CYCLES);
  localparam logic [PHASE_CNT_WIDTH-1:0] PH_MAX =
    PHASE_CNT_WIDTH'(PLL_STEPS_PER_CYCLE - 1);

  pll_state_e state, state_n;

  logic                       locked_s;
  logic                       done_s;
  logic [SCW-1:0]             step_cnt;
  logic [TMO_W-1:0]           tmo_cnt;
  logic                       tmo_hit;
  logic                       accept;
  logic                       sel_ok;
  logic                       tmo_fire;
  logic                       in_wait;
  logic [2:0]                 err_set;
  logic [PHASE_CNT_WIDTH-1:0] phase_cnt [NUM_CLOCKS];

  function automatic logic [PHASE_CNT_WIDTH-1:0] next_phase(
    input logic [PHASE_CNT_WIDTH-1:0] c,
    input logic                       up
  );
    if (up)
      return (c == PH_MAX) ? '0 : c + PHASE_CNT_WIDTH'(1);
    return (c == '0) ? PH_MAX : c - PHASE_CNT_WIDTH'(1);
  endfunction

  altmemddr_phy_sync2 #(.RST_VAL(1'b0)) u_sync_locked (
    .seq_clk     (seq_clk),
    .reset_seq_n (reset_seq_n),
    .d           (pll_locked),
    .q           (locked_s)
  );

  // phasedone idles high, so its synchroniser resets high
  altmemddr_phy_sync2 #(.RST_VAL(1'b1)) u_sync_done (
    .seq_clk     (seq_clk),
    .reset_seq_n (reset_seq_n),
    .d           (pll_phasedone),
    .q           (done_s)
  );

  assign sel_ok  = int'(seq_pll_select) < NUM_CLOCKS;
  assign in_wait = (state == WAIT_LOW) || (state == WAIT_HIGH);

  always_ff @(posedge seq_clk or negedge reset_seq_n) begin
    if (!reset_seq_n) state <= IDLE;
    else              state <= state_n;
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    tmo_fire = 1'b0;
    err_set  = '0;
    unique case (state)
      IDLE: begin
        if (seq_pll_start_reconfig) begin
          err_set[ERR_BUSY]   = !locked_s;
          err_set[ERR_SELECT] = !sel_ok;
          if (locked_s && sel_ok) begin
            accept  = 1'b1;
            state_n = STEP;
          end
        end
      end
      STEP: begin
        if (step_cnt == STEP_LAST) state_n = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!done_s) begin
          state_n = WAIT_HIGH;
        end else if (tmo_cnt == TMO_LIMIT) begin
          tmo_fire = 1'b1;
          state_n  = COMPLETE;
        end
      end
      WAIT_HIGH: begin
        if (done_s) begin
          state_n = COMPLETE;
        end else if (tmo_cnt == TMO_LIMIT) begin
          tmo_fire = 1'b1;
          state_n  = COMPLETE;
        end
      end
      COMPLETE: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (state != IDLE && seq_pll_start_reconfig)
      err_set[ERR_BUSY] = 1'b1;
    err_set[ERR_TIMEOUT] = tmo_fire;
  end

  always_ff @(posedge seq_clk or negedge reset_seq_n) begin
    if (!reset_seq_n) begin
      step_cnt               <= '0;
      tmo_cnt                <= '0;
      tmo_hit                <= 1'b0;
      pll_phasestep          <= 1'b0;
      pll_phaseupdown        <= 1'b0;
      pll_phasecounterselect <= '0;
      phs_shft_busy          <= 1'b1;
      err_flags              <= '0;
    end else begin
      pll_phasestep <= (state_n == STEP);
      // held across the IDLE return so busy drops one cycle after COMPLETE
      phs_shft_busy <= (state_n != IDLE) ||
                       (state != IDLE) || !locked_s;
      err_flags     <= err_flags | err_set;
      if (accept) begin
        pll_phasecounterselect <= seq_pll_select;
        pll_phaseupdown        <= seq_pll_inc_dec_n;
        step_cnt               <= '0;
        tmo_hit                <= 1'b0;
      end else if (state == STEP) begin
        step_cnt <= step_cnt + SCW'(1);
      end
      if (tmo_fire) tmo_hit <= 1'b1;
      if (state_n != state)
        tmo_cnt <= '0;
      else if (in_wait)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge seq_clk or negedge reset_seq_n) begin
    if (!reset_seq_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++)
        phase_cnt[i] <= '0;
    end else if (state == COMPLETE && !tmo_hit) begin
      for (int i = 0; i < NUM_CLOCKS; i++)
        if (pll_phasecounterselect == CLOCK_INDEX_WIDTH'(i))
          phase_cnt[i] <= next_phase(phase_cnt[i],
                                     pll_phaseupdown);
    end
  end

  always_comb begin
    phase_query_value = '0;
    for (int i = 0; i < NUM_CLOCKS; i++)
      if (phase_query_index == CLOCK_INDEX_WIDTH'(i))
        phase_query_value = phase_cnt[i];
  end

endmodule

// File: tb/tb_altmemddr_phy_pll_phase_step_ctrl.sv
// Bench for the PLL phase-step responder: sequencer and PLL models
// drive requests, a per-cycle compare checks outputs against the model.
module tb_altmemddr_phy_pll_phase_step_ctrl;

  localparam int NCLK  = 5;
  localparam int STEPS = 72;

  logic       seq_clk = 1'b0;
  logic       reset_seq_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       seq_pll_start_reconfig = 1'b0;
  logic [2:0] seq_pll_select = '0;
  logic       seq_pll_inc_dec_n = 1'b0;
  logic       phs_shft_busy;
  logic [2:0] pll_phasecounterselect;
  logic       pll_phaseupdown;
  logic       pll_phasestep;
  logic       pll_phasedone = 1'b1;
  logic [2:0] phase_query_index = '0;
  logic [6:0] phase_query_value;
  logic [2:0] err_flags;

  int total = 0;
  int bad   = 0;

  int         mcnt [NCLK];
  logic [2:0] merr     = '0;
  logic [2:0] emask    = 3'b111;
  logic       exp_step = 1'b0;
  logic       exp_up   = 1'b0;
  logic       exp_busy = 1'b1;
  logic [2:0] exp_sel  = '0;
  bit         chk_on   = 1'b0;
  bit         chk_busy = 1'b1;

  always #5 seq_clk = ~seq_clk;

  altmemddr_phy_pll_phase_step_ctrl dut (
    .seq_clk                (seq_clk),
    .reset_seq_n            (reset_seq_n),
    .pll_locked             (pll_locked),
    .seq_pll_start_reconfig (seq_pll_start_reconfig),
    .seq_pll_select         (seq_pll_select),
    .seq_pll_inc_dec_n      (seq_pll_inc_dec_n),
    .phs_shft_busy          (phs_shft_busy),
    .pll_phasecounterselect (pll_phasecounterselect),
    .pll_phaseupdown        (pll_phaseupdown),
    .pll_phasestep          (pll_phasestep),
    .pll_phasedone          (pll_phasedone),
    .phase_query_index      (phase_query_index),
    .phase_query_value      (phase_query_value),
    .err_flags              (err_flags)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int qexp(input logic [2:0] i);
    return (int'(i) < NCLK) ? mcnt[i] : 0;
  endfunction

  always @(negedge seq_clk) begin
    if (chk_on) begin
      check("query", 32'(phase_query_value),
            32'(qexp(phase_query_index)));
      check("err", 32'(err_flags & emask), 32'(merr & emask));
      check("step", 32'(pll_phasestep), 32'(exp_step));
      check("sel", 32'(pll_phasecounterselect), 32'(exp_sel));
      check("updown", 32'(pll_phaseupdown), 32'(exp_up));
      if (chk_busy)
        check("busy", 32'(phs_shft_busy), 32'(exp_busy));
    end
  end

  task automatic tick;
    @(posedge seq_clk);
    #1;
    phase_query_index = 3'($urandom_range(0, 7));
  endtask

  task automatic model_step(input int s, input bit up);
    mcnt[s] = up ? (mcnt[s] + 1) % STEPS
                 : (mcnt[s] + STEPS - 1) % STEPS;
  endtask

  task automatic sync_lock;
    tick;
    tick;
    chk_busy = 1'b0;
    tick;
    exp_busy = 1'b0;
    chk_busy = 1'b1;
    tick;
  endtask

  task automatic request(input int sel, input bit up);
    seq_pll_start_reconfig = 1'b1;
    seq_pll_select         = 3'(sel);
    seq_pll_inc_dec_n      = up;
    tick;
    seq_pll_start_reconfig = 1'b0;
    exp_step = 1'b1;
    exp_sel  = 3'(sel);
    exp_up   = up;
    exp_busy = 1'b1;
    tick;
    tick;
    exp_step = 1'b0;
  endtask

  task automatic do_op(input int sel, input bit up,
                       input bit busy_req);
    int d;
    int k;
    d = $urandom_range(0, 4);
    k = $urandom_range(1, 4);
    request(sel, up);
    repeat (d) tick;
    pll_phasedone = 1'b0;
    if (busy_req) begin
      seq_pll_start_reconfig = 1'b1;
      seq_pll_select    = 3'($urandom_range(0, 7));
      seq_pll_inc_dec_n = 1'($urandom_range(0, 1));
    end
    tick;
    seq_pll_start_reconfig = 1'b0;
    if (busy_req) merr[1] = 1'b1;
    repeat (k - 1) tick;
    pll_phasedone = 1'b1;
    tick;
    tick;
    tick;
    tick;
    model_step(sel, up);
    tick;
    exp_busy = 1'b0;
  endtask

  task automatic idle_bad_sel(input int sel);
    seq_pll_start_reconfig = 1'b1;
    seq_pll_select         = 3'(sel);
    tick;
    seq_pll_start_reconfig = 1'b0;
    merr[2] = 1'b1;
    tick;
  endtask

  task automatic query(input int i, input int want,
                       input string nm);
    phase_query_index = 3'(i);
    #1;
    check(nm, 32'(phase_query_value), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < NCLK; i++) mcnt[i] = 0;
    #2 reset_seq_n = 1'b0;
    #1 chk_on = 1'b1;
    check("rst_busy", 32'(phs_shft_busy), 1);
    check("rst_err", 32'(err_flags), 0);
    repeat (3) tick;
    reset_seq_n = 1'b1;
    repeat (5) tick;
    check("unlocked_busy", 32'(phs_shft_busy), 1);
    pll_locked = 1'b1;
    sync_lock;
    check("locked_busy", 32'(phs_shft_busy), 0);

    do_op(2, 1'b1, 1'b0);
    query(2, 1, "pin_inc2");
    do_op(0, 1'b0, 1'b0);
    query(0, 71, "pin_dec0");
    repeat (STEPS) do_op(1, 1'b1, 1'b0);
    query(1, 0, "pin_wrap1");
    check("pin_err0", 32'(err_flags), 0);

    do_op(3, 1'b1, 1'b1);
    query(3, 1, "pin_busyreq_cnt");
    check("pin_busyreq", 32'(err_flags), 32'(3'b010));
    idle_bad_sel(6);
    check("pin_badsel", 32'(err_flags), 32'(3'b110));
    check("pin_badsel_busy", 32'(phs_shft_busy), 0);

    request(4, 1'b1);
    emask    = 3'b110;
    chk_busy = 1'b0;
    n = 0;
    while (phs_shft_busy === 1'b1 && n < 400) begin
      tick;
      n++;
    end
    check("tmo_wait", 32'(n >= 255 && n < 400), 1);
    merr[0]  = 1'b1;
    emask    = 3'b111;
    exp_busy = 1'b0;
    chk_busy = 1'b1;
    query(4, 0, "pin_tmo_cnt");
    check("pin_tmo_err", 32'(err_flags), 32'(3'b111));

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 7) == 0)
        idle_bad_sel($urandom_range(5, 7));
      do_op($urandom_range(0, NCLK - 1),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0);
    end

    request(2, 1'b1);
    pll_phasedone = 1'b0;
    repeat (4) tick;
    reset_seq_n = 1'b0;
    #1;
    for (int i = 0; i < NCLK; i++) mcnt[i] = 0;
    merr     = '0;
    exp_sel  = '0;
    exp_up   = 1'b0;
    exp_busy = 1'b1;
    check("mid_rst_step", 32'(pll_phasestep), 0);
    check("mid_rst_busy", 32'(phs_shft_busy), 1);
    check("mid_rst_sel", 32'(pll_phasecounterselect), 0);
    for (int i = 0; i < NCLK; i++) query(i, 0, "mid_rst_cnt");
    pll_phasedone = 1'b1;
    tick;
    tick;
    reset_seq_n = 1'b1;
    sync_lock;
    check("mid_rst_err", 32'(err_flags), 0);
    do_op(4, 1'b0, 1'b0);
    query(4, 71, "pin_after_rst");
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
